serial_tx: RTL
==============

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter MAX_BITS, default 256: width of the data word, and the upper limit on bits per frame.
REQ-002 Parameter CW, default 32: width of the timing inputs and of the internal duration counter.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 go  input  1  start request; sampled only in IDLE.
REQ-006 data  input  MAX_BITS  frame payload; bit nbits-1 is sent first (MSB-first); captured when go is accepted.
REQ-007 nbits  input  8  number of bits in the frame; captured when go is accepted.
REQ-008 n0  input  CW  high-pulse width in clk cycles for a 0 bit; captured when go is accepted.
REQ-009 n1  input  CW  high-pulse width in clk cycles for a 1 bit; captured when go is accepted.
REQ-010 ngap  input  CW  low gap in cycles after every pulse; captured when go is accepted.
REQ-011 a  output  1  registered serial line, pulse-width encoded, idles low.
REQ-012 busy  output  1  high while a frame is being sent.
REQ-013 done  output  1  one-cycle pulse at frame end.

Function
REQ-014 The FSM SHALL have states IDLE, HIGH and GAP.
- IDLE->HIGH: go=1 and nbits!=0.
- HIGH->GAP: after the pulse width has elapsed.
- GAP->HIGH: after the gap has elapsed, if bits remain.
- GAP->IDLE: after the gap of the last bit has elapsed.
REQ-015 Accepting go in IDLE SHALL capture data, nbits, n0, n1 and ngap, so that later input changes do not affect the frame in progress.
REQ-016 a SHALL rise in the cycle after go is accepted.
REQ-017 Each bit SHALL be sent as a high pulse followed by a low gap:
- high for exactly n1 cycles for a 1 bit, or n0 cycles for a 0 bit;
- then low for exactly ngap cycles.
REQ-018 A pulse width or gap of 0 SHALL be treated as 1, so that adjacent pulses never merge.
REQ-019 busy SHALL equal 1 exactly when the state is HIGH or GAP.
REQ-020 done SHALL pulse high for one cycle, in the first IDLE cycle after the final gap.
REQ-021 go asserted in the done cycle SHALL be accepted, so that back-to-back frames are sent with no extra idle cycles.
REQ-022 go asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-023 go with nbits=0 SHALL produce a done pulse in the next cycle, with a and busy held low throughout.
REQ-024 Bit selection SHALL use a shift register loaded with data shifted left by MAX_BITS-nbits, so the first bit sent is always the shift-register MSB.
REQ-025 The duration counter SHALL count down from width-1 to 0 with no wrap; the state SHALL advance when the count reaches 0.
REQ-026 Widths up to 2^CW-1 SHALL be supported without overflow.

Reset
REQ-027 While rst=1:
- state=IDLE;
- a=0, busy=0, done=0;
- counter, shift register and captured timing registers cleared.
REQ-028 rst asserted mid-frame SHALL abort the frame in the same edge, with no done pulse.
REQ-029 rst SHALL take priority over go.

Structure
REQ-030 Package serial_pkg SHALL hold:
- the state encoding (IDLE/HIGH/GAP);
- the MAX_BITS and CW defaults.
The same package is shared with serial_rx.
REQ-031 A sub-module pulse_timer SHALL implement the loadable down-counter with a zero flag.
- Ports: clk, rst, load, len, zero.
- serial_tx instantiates it once.

Verification
REQ-032 Nominal frame
- Stimulus: nbits=16, n0=2, n1=3, ngap=1, data=16'h5aaa, go pulse.
- Response: pulse widths 2,3,2,3,3,2,3,2,3,2,3,2,3,2,3,2; busy high for 56 cycles; single done pulse.
- Also checked: output looped into serial_rx (cnt free-running) returns data[15:0]=16'h5aaa.
REQ-033 Zero widths
- Stimulus: n0=0, ngap=0, nbits=4, data=4'b0101.
- Response: pulses 1,w1,1,w1 (w1 = n1 width), each followed by 1 low cycle.
REQ-034 Empty frame
- Stimulus: nbits=0, go.
- Response: done one cycle later; a and busy stay 0.
REQ-035 go while busy and back-to-back frames
- Stimulus: go pulsed mid-frame, then go held high through done.
- Response: the mid-frame go is ignored; the second frame's a rises on the cycle after done.
REQ-036 Reset mid-frame
- Stimulus: rst=1 during a HIGH phase.
- Response: next cycle a=0, busy=0, done=0; a subsequent go starts a clean frame.
REQ-037 Wide frame
- Stimulus: nbits=255, n0=1, n1=1, ngap=1, data=all-ones.
- Response: 255 alternating pulses; busy high for 510 cycles.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the pulse-width serial link (serial_tx / serial_rx).
// Holds the FSM state encoding and the default sizing parameters.
package serial_pkg;

  localparam int MAX_BITS_DEFAULT = 256;
  localparam int CW_DEFAULT       = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter: counts from len to 0 and holds there; zero flags
// the final cycle of a timed phase.
module pulse_timer
  import serial_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] len,
  output logic          zero
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = len;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/serial_tx.sv
// Pulse-width serial transmitter: each bit is a high pulse (n1 or n0 cycles)
// followed by an ngap-cycle low gap, MSB-first, with a done pulse per frame.
module serial_tx
  import serial_pkg::*;
#(
  parameter int MAX_BITS = MAX_BITS_DEFAULT,
  parameter int CW       = CW_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic [MAX_BITS-1:0] data,
  input  logic [7:0]          nbits,
  input  logic [CW-1:0]       n0,
  input  logic [CW-1:0]       n1,
  input  logic [CW-1:0]       ngap,
  output logic                a,
  output logic                busy,
  output logic                done
);

  state_e              state_q, state_d;
  logic [MAX_BITS-1:0] sh_q, sh_d;
  logic [7:0]          bits_q, bits_d;
  logic [CW-1:0]       n0_q, n0_d;
  logic [CW-1:0]       n1_q, n1_d;
  logic [CW-1:0]       ngap_q, ngap_d;
  logic                a_q, a_d;
  logic                done_q, done_d;

  logic                timer_load;
  logic [CW-1:0]       timer_len;
  logic                timer_zero;
  logic [31:0]         shamt;
  logic [MAX_BITS-1:0] start_sh;

  // A width of 0 behaves as 1; the counter runs width-1 down to 0.
  function automatic logic [CW-1:0] to_len(input logic [CW-1:0] w);
    return (w == '0) ? '0 : w - 1'b1;
  endfunction

  pulse_timer #(.CW(CW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .len  (timer_len),
    .zero (timer_zero)
  );

  assign shamt    = 32'(MAX_BITS) - 32'(nbits);
  assign start_sh = data << shamt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      bits_q  <= '0;
      n0_q    <= '0;
      n1_q    <= '0;
      ngap_q  <= '0;
      a_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bits_q  <= bits_d;
      n0_q    <= n0_d;
      n1_q    <= n1_d;
      ngap_q  <= ngap_d;
      a_q     <= a_d;
      done_q  <= done_d;
    end
  end

  // bits_q counts bits still to send; it is decremented when a pulse ends.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bits_d     = bits_q;
    n0_d       = n0_q;
    n1_d       = n1_q;
    ngap_d     = ngap_q;
    timer_load = 1'b0;
    timer_len  = '0;
    case (state_q)
      ST_IDLE: begin
        if (go && (nbits != 8'd0)) begin
          state_d    = ST_HIGH;
          sh_d       = start_sh;
          bits_d     = nbits;
          n0_d       = n0;
          n1_d       = n1;
          ngap_d     = ngap;
          timer_load = 1'b1;
          timer_len  = start_sh[MAX_BITS-1] ? to_len(n1) : to_len(n0);
        end
      end
      ST_HIGH: begin
        if (timer_zero) begin
          state_d    = ST_GAP;
          sh_d       = sh_q << 1;
          bits_d     = bits_q - 8'd1;
          timer_load = 1'b1;
          timer_len  = to_len(ngap_q);
        end
      end
      ST_GAP: begin
        if (timer_zero) begin
          if (bits_q != 8'd0) begin
            state_d    = ST_HIGH;
            timer_load = 1'b1;
            timer_len  = sh_q[MAX_BITS-1] ? to_len(n1_q) : to_len(n0_q);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    a_d    = (state_d == ST_HIGH);
    done_d = ((state_q == ST_GAP) && timer_zero && (bits_q == 8'd0)) ||
             ((state_q == ST_IDLE) && go && (nbits == 8'd0));
    busy   = (state_q == ST_HIGH) || (state_q == ST_GAP);
  end

  assign a    = a_q;
  assign done = done_q;

endmodule
